// File: rtl/nfc_pkg.sv
// rtl/nfc_pkg.sv - shared NFC constants: ACG bit indices, CA-latch state encoding, default timing
package nfc_pkg;

  localparam int ACG_CA_BIT   = 6;
  localparam int CA_MAX_BYTES = 5;

  localparam int DEF_TCS = 2;
  localparam int DEF_TWP = 3;
  localparam int DEF_TWH = 2;
  localparam int DEF_TWB = 10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_WE_LOW   = 3'd2;
  localparam logic [2:0] ST_WE_HIGH  = 3'd3;
  localparam logic [2:0] ST_TWB_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam logic [2:0] ST_RECOVER  = 3'd6;

  typedef enum logic [2:0] {
    sIdle    = ST_IDLE,
    sSetup   = ST_SETUP,
    sWeLow   = ST_WE_LOW,
    sWeHigh  = ST_WE_HIGH,
    sTwbWait = ST_TWB_WAIT,
    sDone    = ST_DONE,
    sRecover = ST_RECOVER
  } caState_t;

  // Cycle counts below a floor are raised to it, then narrowed to the 8-bit counter width.
  function automatic logic [7:0] effCycles(input int value, input int minimum);
    return (value < minimum) ? 8'(minimum) : 8'(value);
  endfunction

endpackage

// File: rtl/nfc_timing_counter.sv
// rtl/nfc_timing_counter.sv - loadable 8-bit down-counter; oDone while the count sits at zero
module nfc_timing_counter (
  input  logic       iSystemClock,
  input  logic       iReset,
  input  logic       iLoad,
  input  logic [7:0] iLoadValue,
  output logic [7:0] oCount,
  output logic       oDone
);

  assign oDone = (oCount == 8'd0);

  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      oCount <= 8'd0;
    end else if (iLoad) begin
      oCount <= iLoadValue;
    end else if (!oDone) begin
      oCount <= oCount - 8'd1;
    end
  end

endmodule

// File: rtl/nfc_atom_ca_latch.sv
// rtl/nfc_atom_ca_latch.sv - ACG bit-6 responder: NAND async command/address latch cycles (0-5 bytes)
// Optional post-write tWB wait state is enabled by defining NFC_CA_TWB_WAIT_EN.
module nfc_atom_ca_latch
  import nfc_pkg::*;
#(
  parameter int NumberOfWays = 4,
  parameter int TCS          = DEF_TCS,
  parameter int TWP          = DEF_TWP,
  parameter int TWH          = DEF_TWH,
  parameter int TWB          = DEF_TWB
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [7:0]              iCommand,
  input  logic [2:0]              iCommandOption,
  input  logic [NumberOfWays-1:0] iTargetWay,
  input  logic [15:0]             iNumOfData,
  input  logic                    iCASelect,
  input  logic [39:0]             iCAData,
  output logic                    oReady,
  output logic                    oLastStep,
  output logic [NumberOfWays-1:0] oCE_n,
  output logic                    oCLE,
  output logic                    oALE,
  output logic                    oWE_n,
  output logic [7:0]              oDQ,
  output logic                    oDQOE
);

  // Counters are loaded with (cycles - 1) so oDone marks the final cycle of a phase.
  localparam logic [7:0] tcsLoad = effCycles(TCS, 1) - 8'd1;
  localparam logic [7:0] twpLoad = effCycles(TWP, 1) - 8'd1;
  localparam logic [7:0] twhLoad = effCycles(TWH, 2) - 8'd1;
`ifdef NFC_CA_TWB_WAIT_EN
  localparam logic [7:0] twbLoad = effCycles(TWB, 1) - 8'd1;
`endif

  caState_t                state;
  caState_t                nextState;
  logic [NumberOfWays-1:0] wayMask;
  logic                    caSelect;
  logic [39:0]             shiftData;
  logic [2:0]              bytesLeft;
  logic                    counterLoad;
  logic [7:0]              counterLoadValue;
  logic [7:0]              counterCount;
  logic                    counterDone;
  logic                    start;
  logic [2:0]              numClamped;

  wire unusedInputs = ^{iCommandOption, iCommand, 8'(TWB)};

  assign start      = (state == sIdle) && iCommand[ACG_CA_BIT];
  assign numClamped = (iNumOfData > 16'(CA_MAX_BYTES)) ? 3'(CA_MAX_BYTES) : iNumOfData[2:0];

  nfc_timing_counter uTimingCounter (
    .iSystemClock (iSystemClock),
    .iReset       (iReset),
    .iLoad        (counterLoad),
    .iLoadValue   (counterLoadValue),
    .oCount       (counterCount),
    .oDone        (counterDone)
  );

  always_ff @(posedge iSystemClock or negedge iReset) begin
    if (!iReset) begin
      state     <= sIdle;
      wayMask   <= '0;
      caSelect  <= 1'b0;
      shiftData <= 40'd0;
      bytesLeft <= 3'd0;
    end else begin
      state <= nextState;
      if (start) begin
        wayMask   <= iTargetWay;
        caSelect  <= iCASelect;
        shiftData <= iCAData;
        bytesLeft <= numClamped;
      end else if (state == sWeHigh && bytesLeft > 3'd1) begin
        // Next byte appears on DQ from the second WE# high cycle onward.
        if (counterCount == twhLoad) begin
          shiftData <= {shiftData[31:0], 8'h00};
        end
        if (counterDone) begin
          bytesLeft <= bytesLeft - 3'd1;
        end
      end
    end
  end

  always_comb begin
    nextState        = state;
    counterLoad      = 1'b0;
    counterLoadValue = 8'd0;
    oReady           = 1'b0;
    oLastStep        = 1'b0;
    oCE_n            = '1;
    oCLE             = 1'b0;
    oALE             = 1'b0;
    oWE_n            = 1'b1;
    oDQOE            = 1'b0;

    if (state == sSetup || state == sWeLow || state == sWeHigh) begin
      oCE_n = ~wayMask;
      oCLE  = caSelect;
      oALE  = ~caSelect;
      oDQOE = 1'b1;
    end

    case (state)
      sIdle: begin
        oReady = 1'b1;
        if (start) begin
          if (numClamped == 3'd0) begin
            nextState = sDone;
          end else begin
            nextState        = sSetup;
            counterLoad      = 1'b1;
            counterLoadValue = tcsLoad;
          end
        end
      end
      sSetup: begin
        if (counterDone) begin
          nextState        = sWeLow;
          counterLoad      = 1'b1;
          counterLoadValue = twpLoad;
        end
      end
      sWeLow: begin
        oWE_n = 1'b0;
        if (counterDone) begin
          nextState        = sWeHigh;
          counterLoad      = 1'b1;
          counterLoadValue = twhLoad;
        end
      end
      sWeHigh: begin
        if (counterDone) begin
          if (bytesLeft > 3'd1) begin
            nextState        = sWeLow;
            counterLoad      = 1'b1;
            counterLoadValue = twpLoad;
          end else begin
`ifdef NFC_CA_TWB_WAIT_EN
            nextState        = sTwbWait;
            counterLoad      = 1'b1;
            counterLoadValue = twbLoad;
`else
            nextState        = sDone;
`endif
          end
        end
      end
`ifdef NFC_CA_TWB_WAIT_EN
      sTwbWait: begin
        oCE_n = ~wayMask;
        if (counterDone) begin
          nextState = sDone;
        end
      end
`endif
      sDone: begin
        oLastStep = 1'b1;
        nextState = sRecover;
      end
      sRecover: begin
        nextState = sIdle;
      end
      default: begin
        nextState = sIdle;
      end
    endcase

    oDQ = oDQOE ? shiftData[39:32] : 8'h00;
  end

endmodule

// File: tb/tb_nfc_atom_ca_latch.sv
// tb/tb_nfc_atom_ca_latch.sv - directed self-checking bench for nfc_atom_ca_latch (default build)
module tb_nfc_atom_ca_latch;

  logic        iSystemClock = 1'b0;
  logic        iReset;
  logic [7:0]  iCommand;
  logic [2:0]  iCommandOption;
  logic [3:0]  iTargetWay;
  logic [15:0] iNumOfData;
  logic        iCASelect;
  logic [39:0] iCAData;
  logic        oReady;
  logic        oLastStep;
  logic [3:0]  oCE_n;
  logic        oCLE;
  logic        oALE;
  logic        oWE_n;
  logic [7:0]  oDQ;
  logic        oDQOE;

  int checkCount = 0;
  int errorCount = 0;

  // Trace index j holds the outputs seen in cycle k+j, where k is the start edge.
  logic       trWe[64];
  logic       trLast[64];
  logic       trReady[64];
  logic       trCle[64];
  logic       trAle[64];
  logic       trOe[64];
  logic [3:0] trCe[64];
  logic [7:0] trDq[64];

  int          firstWeLow;
  int          lastWeLowOfFirst;
  int          pulseCount;
  int          lastStepAt;
  int          lastStepCount;
  int          readyAt;
  int          ceActiveCount;
  logic [39:0] latchedBytes;

  nfc_atom_ca_latch dut (
    .iSystemClock   (iSystemClock),
    .iReset         (iReset),
    .iCommand       (iCommand),
    .iCommandOption (iCommandOption),
    .iTargetWay     (iTargetWay),
    .iNumOfData     (iNumOfData),
    .iCASelect      (iCASelect),
    .iCAData        (iCAData),
    .oReady         (oReady),
    .oLastStep      (oLastStep),
    .oCE_n          (oCE_n),
    .oCLE           (oCLE),
    .oALE           (oALE),
    .oWE_n          (oWE_n),
    .oDQ            (oDQ),
    .oDQOE          (oDQOE)
  );

  always #5 iSystemClock = ~iSystemClock;

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issue a command at edge k, record `cycles` cycles, release iCommand from cycle k+dropAt on.
  task automatic runTxn(input logic [7:0] cmd, input logic [3:0] way, input logic sel,
                        input logic [39:0] data, input logic [15:0] num,
                        input int dropAt, input int cycles);
    @(negedge iSystemClock);
    iCommand   = cmd;
    iTargetWay = way;
    iCASelect  = sel;
    iCAData    = data;
    iNumOfData = num;
    for (int j = 1; j <= cycles; j++) begin
      @(negedge iSystemClock);
      trWe[j]    = oWE_n;
      trLast[j]  = oLastStep;
      trReady[j] = oReady;
      trCle[j]   = oCLE;
      trAle[j]   = oALE;
      trOe[j]    = oDQOE;
      trCe[j]    = oCE_n;
      trDq[j]    = oDQ;
      if (j >= dropAt) begin
        iCommand   = 8'h00;
        iTargetWay = 4'b0000;
        iCAData    = 40'h0;
        iNumOfData = 16'd0;
      end
    end
    firstWeLow       = -1;
    lastWeLowOfFirst = -1;
    pulseCount       = 0;
    lastStepAt       = -1;
    lastStepCount    = 0;
    readyAt          = -1;
    ceActiveCount    = 0;
    latchedBytes     = 40'h0;
    for (int j = 1; j <= cycles; j++) begin
      if (trCe[j] != 4'b1111) ceActiveCount++;
      if (!trWe[j] && firstWeLow < 0) firstWeLow = j;
      if (!trWe[j] && (j == cycles || trWe[j+1])) begin
        pulseCount++;
        latchedBytes = {latchedBytes[31:0], trDq[j]};
        if (lastWeLowOfFirst < 0) lastWeLowOfFirst = j;
      end
      if (trLast[j]) begin
        lastStepCount++;
        if (lastStepAt < 0) lastStepAt = j;
      end
      if (lastStepAt > 0 && j > lastStepAt && trReady[j] && readyAt < 0) readyAt = j;
    end
  endtask

  initial begin
    iReset         = 1'b0;
    iCommand       = 8'h00;
    iCommandOption = 3'b000;
    iTargetWay     = 4'b0000;
    iNumOfData     = 16'd0;
    iCASelect      = 1'b0;
    iCAData        = 40'h0;
    repeat (3) @(negedge iSystemClock);

    checkValue("rst_ready", oReady, 1);
    checkValue("rst_last", oLastStep, 0);
    checkValue("rst_ce", oCE_n, 4'b1111);
    checkValue("rst_cle_ale", {oCLE, oALE}, 2'b00);
    checkValue("rst_we", oWE_n, 1);
    checkValue("rst_dq", oDQ, 8'h00);
    checkValue("rst_oe", oDQOE, 0);
    iReset = 1'b1;
    repeat (2) @(negedge iSystemClock);

    // Command cycle, one byte; iCommand held through k+9 must not retrigger.
    runTxn(8'h40, 4'b0001, 1'b1, 40'hFF_0000_0000, 16'd1, 10, 24);
    checkValue("s1_cle", trCle[1], 1);
    checkValue("s1_ale", trAle[1], 0);
    checkValue("s1_ce", trCe[1], 4'b1110);
    checkValue("s1_dq", trDq[1], 8'hFF);
    checkValue("s1_oe", trOe[1], 1);
    checkValue("s1_ready_busy", trReady[1], 0);
    checkValue("s1_we_first", firstWeLow, 3);
    checkValue("s1_we_last", lastWeLowOfFirst, 5);
    checkValue("s1_pulses", pulseCount, 1);
    checkValue("s1_bytes", latchedBytes, 40'h00_0000_00FF);
    checkValue("s1_laststep", lastStepAt, 8);
    checkValue("s1_laststep_once", lastStepCount, 1);
    checkValue("s1_ready", readyAt, 10);
    checkValue("s1_done_ce", trCe[8], 4'b1111);
    checkValue("s1_ready_end", trReady[24], 1);

    // Address cycles, five bytes.
    runTxn(8'h40, 4'b0100, 1'b0, 40'h01_0203_0405, 16'd5, 1, 34);
    checkValue("s2_ale", trAle[1], 1);
    checkValue("s2_cle", trCle[1], 0);
    checkValue("s2_ce", trCe[1], 4'b1011);
    checkValue("s2_pulses", pulseCount, 5);
    checkValue("s2_bytes", latchedBytes, 40'h01_0203_0405);
    checkValue("s2_laststep", lastStepAt, 28);
    checkValue("s2_ready", readyAt, 30);

    // Zero bytes: completion without pin activity.
    runTxn(8'h40, 4'b0001, 1'b1, 40'hAA_BBCC_DDEE, 16'd0, 1, 8);
    checkValue("s3_pulses", pulseCount, 0);
    checkValue("s3_ce_active", ceActiveCount, 0);
    checkValue("s3_oe", trOe[1], 0);
    checkValue("s3_laststep", lastStepAt, 1);
    checkValue("s3_ready", readyAt, 3);

    // Count above five is clamped.
    runTxn(8'h40, 4'b1000, 1'b0, 40'h11_2233_4455, 16'd9, 1, 34);
    checkValue("s4_pulses", pulseCount, 5);
    checkValue("s4_bytes", latchedBytes, 40'h11_2233_4455);
    checkValue("s4_laststep", lastStepAt, 28);

    // Other command bits are ignored.
    runTxn(8'h08, 4'b1111, 1'b1, 40'hFF_FFFF_FFFF, 16'd3, 12, 12);
    checkValue("s5_pulses", pulseCount, 0);
    checkValue("s5_ce_active", ceActiveCount, 0);
    checkValue("s5_laststep", lastStepCount, 0);
    checkValue("s5_ready", trReady[12], 1);

    // Reset asserted mid WE# low pulse.
    @(negedge iSystemClock);
    iCommand   = 8'h40;
    iTargetWay = 4'b0010;
    iCASelect  = 1'b1;
    iCAData    = 40'h5A_0000_0000;
    iNumOfData = 16'd1;
    @(negedge iSystemClock);
    iCommand = 8'h00;
    repeat (3) @(negedge iSystemClock);
    checkValue("s6_we_low_pre", oWE_n, 0);
    #2;
    iReset = 1'b0;
    #1;
    checkValue("s6_we", oWE_n, 1);
    checkValue("s6_ce", oCE_n, 4'b1111);
    checkValue("s6_ready", oReady, 1);
    checkValue("s6_dq_oe", {oDQ, oDQOE}, 9'h000);
    @(negedge iSystemClock);
    iReset = 1'b1;
    runTxn(8'h40, 4'b0001, 1'b1, 40'hC3_0000_0000, 16'd1, 1, 14);
    checkValue("s6_restart_pulses", pulseCount, 1);
    checkValue("s6_restart_bytes", latchedBytes, 40'h00_0000_00C3);
    checkValue("s6_restart_laststep", lastStepAt, 8);
    checkValue("s6_restart_ready", readyAt, 10);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/nfc_atom_ca_latch.md
# nfc_atom_ca_latch

- Responder end of the atomic-command (ACG) interface for command bit 6, command/address latch.
- Accepts one-hot command requests from the NFC command FSMs and drives the NAND asynchronous-mode CE#/CLE/ALE/WE#/DQ waveforms for 0–5 command or address bytes.
- Reports completion to the requester through its ready and last-step bits.
- Sits between the command FSMs and the NAND pin multiplexer, alongside the other atomic generators.

## Interface
Parameters:
- NumberOfWays, 4, number of chip-enable ways
- TCS, 2, setup cycles (CE#/CLE/ALE/DQ valid before WE# falls)
- TWP, 3, WE# low cycles
- TWH, 2, WE# high cycles per byte, minimum 2
- TWB, 10, post-write wait cycles (only with NFC_CA_TWB_WAIT_EN)

Ports:
- iSystemClock  in  1  system clock; one clock domain
- iReset  in  1  asynchronous, active-low reset
- iCommand  in  8  one-hot atomic command; only bit 6 is used
- iCommandOption  in  3  ignored
- iTargetWay  in  NumberOfWays  way mask, latched at start
- iNumOfData  in  16  byte count, latched at start
- iCASelect  in  1  1 = command cycles (CLE), 0 = address cycles (ALE)
- iCAData  in  40  bytes to send, [39:32] first
- oReady  out  1  idle; feeds requester Ready[6]
- oLastStep  out  1  one-cycle completion pulse; feeds requester LastStep[6]
- oCE_n  out  NumberOfWays  chip enables, active-low
- oCLE, oALE  out  1 each  latch enables
- oWE_n  out  1  write enable, active-low
- oDQ  out  8  data bus
- oDQOE  out  1  DQ output enable

## Operation
- Start condition: oReady & iCommand[6] sampled on a clock edge.
  - At start, latch iTargetWay, iCASelect, iCAData, and the byte count N = min(iNumOfData, 5).
- State machine: IDLE → SETUP → WE_LOW → WE_HIGH → (WE_LOW while bytes remain) → [TWB_WAIT] → DONE → RECOVER → IDLE.
- IDLE:
  - oReady=1, CE_n all 1, CLE=ALE=0, WE_n=1, DQOE=0.
  - On start with N=0, go directly to DONE with no pin activity.
- SETUP (TCS cycles):
  - oReady=0.
  - oCE_n = ~way mask.
  - CLE = CASelect, ALE = ~CASelect.
  - DQ = byte0, DQOE=1.
- WE_LOW (TWP cycles): oWE_n=0.
- WE_HIGH (TWH cycles):
  - oWE_n=1.
  - On the second cycle, DQ shifts to the next byte if one remains.
  - After the last byte: go to TWB_WAIT (macro on) or DONE.
- DONE (1 cycle): oLastStep=1, CLE=ALE=0, DQOE=0, CE_n all 1.
- RECOVER (1 cycle): oReady stays 0.
  - Guards against restart: the requester still holds iCommand[6] in the cycle it observes LastStep.
- Timing parameters of 0 are treated as 1. Internal counters are 8-bit.
- Reset (asserted at any time, including mid-byte):
  - Outputs immediately go to oReady=1, oLastStep=0, CE_n all 1, CLE=ALE=0, WE_n=1, DQ=0, DQOE=0.
  - FSM returns to IDLE.

## Timing
- Start sampled at edge k. For N≥1, without the macro:
  - SETUP occupies k+1..k+TCS.
  - Byte i occupies TWP+TWH cycles.
  - oLastStep is high at k+1+TCS+N·(TWP+TWH).
  - oReady returns 2 cycles after the LastStep cycle.
- N=0: oLastStep at k+1, oReady at k+3.
- iCommand bits other than 6, and changes on inputs after start, have no effect until IDLE.

## Configuration
- NFC_CA_TWB_WAIT_EN defined:
  - Adds the TWB_WAIT state: TWB cycles after the final WE_HIGH, WE_n=1, CE_n still asserted.
  - This delays oLastStep by TWB cycles, so R/B# is valid when the requester samples ready/busy.
- Undefined: state absent; WE_HIGH proceeds directly to DONE.

## Structure
- Shared package nfc_pkg:
  - ACG bit-index constants (ACG_CA_BIT=6).
  - State encoding localparams.
  - Default timing constants.
- One sub-module, nfc_timing_counter: loadable 8-bit down-counter with a done flag. It is reused for TCS, TWP, TWH and TWB.

## Test plan
- Defaults; iCASelect=1, N=1, iCAData=FF_0000_0000, way=0001, start at k:
  - CLE=1, DQ=FFh, oCE_n=1110.
  - WE_n low k+3..k+5.
  - oLastStep at k+8; oReady=1 at k+10.
- iCASelect=0, N=5, iCAData=01_0203_0405, way=0100:
  - ALE=1, oCE_n=1011.
  - Five WE_n pulses latching DQ 01,02,03,04,05.
  - oLastStep at k+28.
- N=0 → no WE_n pulse, oLastStep at k+1, oReady at k+3. N=9 → exactly 5 pulses.
- iCommand[6] held through cycle k+9 of the first scenario → no second transaction. iCommand=08h in IDLE → no activity.
- iReset low during WE_LOW → same cycle: WE_n=1, CE_n=1111, oReady=1. After release, a new start works normally.
- NFC_CA_TWB_WAIT_EN with TWB=10 on the first scenario → oLastStep at k+18, CE_n held low through k+17.
